page_xlate: RTL and testbench
=============================

Name: page_xlate

Overview:
- Address-translation front end that sits directly upstream of the page directory/table memory.
- Accepts CPU virtual-address requests and looks them up in a small fully-associative TLB.
- On a miss, fetches the directory entry (16-bit frame ref + 2-bit status) from the page memory over a req/ack handshake, then fills the TLB.
- Returns the physical address or a fault to the CPU; honours the page memory's PINV invalidate.

Parameters:
- TLB_N, 4, number of TLB entries (power of 2, 2..16)
- VPN_W, 8, virtual page number width; equals the directory index width (256 entries)
- OFF_W, 8, page offset width
- REF_W, 16, physical frame reference width

Ports:
- SCLK  in  1  system clock, all logic on rising edge
- SRST  in  1  synchronous active-low reset
- cpu_req  in  1  single-cycle request pulse; accepted only when busy=0
- cpu_rw  in  1  1=write, 0=read; sampled with cpu_req
- cpu_va  in  VPN_W+OFF_W  virtual address {vpn, offset}; sampled with cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_pa  out  REF_W+OFF_W  physical address {ref, offset}; valid while cpu_ack=1
- cpu_fault  out  1  valid with cpu_ack; 1 = translation denied (cpu_pa forced to 0)
- busy  out  1  high in every state except IDLE
- pt_req  out  1  directory read request, level, held until pt_ack
- pt_idx  out  VPN_W  directory index; stable while pt_req=1
- pt_ack  in  1  one-cycle; pt_ref/pt_status valid in the same cycle
- pt_ref  in  REF_W  frame reference from the directory
- pt_status  in  2  entry status from the directory
- PINV  in  1  page-invalidate from the page memory; flush the whole TLB
- hit_cnt  out  16  saturating TLB hit count
- miss_cnt  out  16  saturating TLB miss count

Behaviour:
- Reset (SRST=0 at an edge): state IDLE; all TLB valid bits 0; round-robin pointer 0; all outputs 0 (cpu_ack, cpu_pa, cpu_fault, busy, pt_req, pt_idx, hit_cnt, miss_cnt). Reset mid-walk drops pt_req at that edge; a later stray pt_ack is ignored.
- Status encoding:
  - 00 not present: fault.
  - 01 valid read/write.
  - 10 valid read-only: a write faults.
  - 11 reserved: fault.
- FSM states: IDLE, LOOKUP, WALK, RESP.
- IDLE -> LOOKUP: on cpu_req=1; latch va and rw.
- LOOKUP: compare the latched vpn against all valid tags in parallel.
  - Hit: go to RESP; hit_cnt+1.
  - Miss: go to WALK with pt_req=1 and pt_idx=vpn; miss_cnt+1.
- WALK: hold pt_req until pt_ack. On pt_ack:
  - Capture ref/status; pt_req=0 at the same edge; go to RESP.
  - Status 01 or 10: fill the TLB.
  - Status 00 or 11: no fill.
- RESP: cpu_ack=1 for exactly one cycle, cpu_pa/cpu_fault driven; next state IDLE.
- Latency:
  - Hit: cpu_ack 2 cycles after the cpu_req edge.
  - Miss: ack 1 cycle after the pt_ack edge.
- Fault is evaluated on the status used for the response (TLB copy on a hit, pt_status on a miss) together with the latched rw.
- Fill victim selection:
  - Lowest-index invalid entry if one exists.
  - Otherwise the entry at the round-robin pointer, and the pointer increments modulo TLB_N.
- Duplicate tags are impossible: fill happens only after a miss.
- PINV=1 at any edge clears all valid bits.
  - PINV and a fill at the same edge: invalidate wins, fill discarded.
  - The in-flight response is still delivered with the fetched values.
  - PINV in LOOKUP takes effect after the compare of that cycle.
- cpu_req while busy=1 is dropped, with no state change and no counter change.
- Counters saturate at 16'hFFFF.

Decomposition:
- Shared package page_pkg holds:
  - Width constants VPN_W, OFF_W, REF_W.
  - Status encodings ST_NP, ST_RW, ST_RO, ST_RSV.
  - FSM state enum.
- One sub-module, page_tlb, holds the entry array (tag, ref, status, valid) and provides:
  - Combinational parallel compare: hit and hit data.
  - Registered fill with victim selection and round-robin pointer.
  - Flush.
- page_xlate holds the FSM, handshakes and counters.

Test Plan:
- Reset then cpu_req va=16'h0312 rw=0; directory returns ref=16'hABCD st=01 -> pt_req with pt_idx=8'h03; cpu_ack, cpu_pa=24'hABCD12, fault=0; miss_cnt=1.
- Repeat va=16'h0344 -> no pt_req; cpu_ack exactly 2 cycles after request; pa=24'hABCD44; hit_cnt=1.
- Write to vpn 8'h05 with st=10 -> fault=1, pa=0. A following read to vpn 5 hits with fault=0.
- Miss with st=00 -> fault=1, no fill; a repeat request misses again, miss_cnt=2 for that vpn.
- Fill 5 distinct vpns with TLB_N=4 -> 5th evicts entry 0; re-access of the first vpn misses.
- PINV pulsed in the same cycle as pt_ack -> response delivered; next access to that vpn misses. Reset asserted while pt_req=1 -> pt_req=0 next cycle; a late pt_ack produces no cpu_ack.

Source files
------------

// File: rtl/page_pkg.sv
// Shared widths, directory status encodings and FSM states for the page translator.
package page_pkg;
    localparam int VPN_W = 8;
    localparam int OFF_W = 8;
    localparam int REF_W = 16;
    localparam int VA_W  = VPN_W + OFF_W;
    localparam int PA_W  = REF_W + OFF_W;

    localparam logic [1:0] ST_NP  = 2'b00;
    localparam logic [1:0] ST_RW  = 2'b01;
    localparam logic [1:0] ST_RO  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_t;

    // Denied when not present, reserved, or a write to a read-only page.
    function automatic logic is_fault(input logic [1:0] st, input logic rw);
        return (st == ST_NP) || (st == ST_RSV) || ((st == ST_RO) && rw);
    endfunction
endpackage

// File: rtl/page_tlb.sv
// Fully-associative TLB: parallel tag compare, fill with invalid-first / round-robin victim, flush.
module page_tlb
    import page_pkg::*;
#(
    parameter int TLB_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VPN_W-1:0] vpn,
    output logic             hit,
    output logic [REF_W-1:0] hit_frame,
    output logic [1:0]       hit_st,
    input  logic             fill,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [REF_W-1:0] fill_frame,
    input  logic [1:0]       fill_st,
    input  logic             flush
);
    localparam int IW = $clog2(TLB_N);

    logic [TLB_N-1:0] vld;
    logic [VPN_W-1:0] tag   [TLB_N];
    logic [REF_W-1:0] frame [TLB_N];
    logic [1:0]       st    [TLB_N];
    logic [IW-1:0]    rr;
    logic [IW-1:0]    victim;
    logic             free;

    always_comb begin
        hit       = 1'b0;
        hit_frame = '0;
        hit_st    = ST_NP;
        for (int i = 0; i < TLB_N; i++) begin
            if (vld[i] && tag[i] == vpn) begin
                hit       = 1'b1;
                hit_frame = frame[i];
                hit_st    = st[i];
            end
        end
    end

    // Walk downward so the lowest-index invalid entry wins.
    always_comb begin
        free   = 1'b0;
        victim = rr;
        for (int i = TLB_N - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free   = 1'b1;
                victim = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            rr  <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (fill) begin
            vld[victim] <= 1'b1;
            if (!free) rr <= rr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag[victim]   <= fill_vpn;
            frame[victim] <= fill_frame;
            st[victim]    <= fill_st;
        end
    end
endmodule

// File: rtl/page_xlate.sv
// Translation front end: TLB lookup, directory walk on miss, CPU response and hit/miss counters.
module page_xlate
    import page_pkg::*;
#(
    parameter int TLB_N = 4
) (
    input  logic             SCLK,
    input  logic             SRST,
    input  logic             cpu_req,
    input  logic             cpu_rw,
    input  logic [VA_W-1:0]  cpu_va,
    output logic             cpu_ack,
    output logic [PA_W-1:0]  cpu_pa,
    output logic             cpu_fault,
    output logic             busy,
    output logic             pt_req,
    output logic [VPN_W-1:0] pt_idx,
    input  logic             pt_ack,
    input  logic [REF_W-1:0] pt_ref,
    input  logic [1:0]       pt_status,
    input  logic             PINV,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
);
    state_t           state, next;
    logic [VA_W-1:0]  va_q;
    logic             rw_q;
    logic [VPN_W-1:0] vpn;
    logic             hit;
    logic [REF_W-1:0] hit_frame;
    logic [1:0]       hit_st;
    logic             load;
    logic             fill;
    logic [REF_W-1:0] rsp_frame;
    logic [1:0]       rsp_st;
    logic             rsp_fault;

    assign vpn     = va_q[VA_W-1:OFF_W];
    assign busy    = (state != S_IDLE);
    assign cpu_ack = (state == S_RESP);

    page_tlb #(.TLB_N(TLB_N)) u_tlb (
        .clk        (SCLK),
        .rst_n      (SRST),
        .vpn        (vpn),
        .hit        (hit),
        .hit_frame  (hit_frame),
        .hit_st     (hit_st),
        .fill       (fill),
        .fill_vpn   (vpn),
        .fill_frame (pt_ref),
        .fill_st    (pt_status),
        .flush      (PINV)
    );

    always_ff @(posedge SCLK) begin
        if (!SRST) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next      = state;
        load      = 1'b0;
        fill      = 1'b0;
        rsp_frame = pt_ref;
        rsp_st    = pt_status;
        case (state)
            S_IDLE:   if (cpu_req) next = S_LOOKUP;
            S_LOOKUP: begin
                if (hit) begin
                    next      = S_RESP;
                    load      = 1'b1;
                    rsp_frame = hit_frame;
                    rsp_st    = hit_st;
                end else begin
                    next = S_WALK;
                end
            end
            S_WALK: begin
                if (pt_ack) begin
                    next = S_RESP;
                    load = 1'b1;
                    fill = (pt_status == ST_RW) || (pt_status == ST_RO);
                end
            end
            S_RESP:   next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    assign rsp_fault = is_fault(rsp_st, rw_q);

    always_ff @(posedge SCLK) begin
        if (!SRST) begin
            va_q      <= '0;
            rw_q      <= 1'b0;
            pt_req    <= 1'b0;
            pt_idx    <= '0;
            cpu_pa    <= '0;
            cpu_fault <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (state == S_IDLE && cpu_req) begin
                va_q <= cpu_va;
                rw_q <= cpu_rw;
            end
            if (state == S_LOOKUP) begin
                if (hit) begin
                    if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                end else begin
                    if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    pt_req <= 1'b1;
                    pt_idx <= vpn;
                end
            end
            if (state == S_WALK && pt_ack) pt_req <= 1'b0;
            if (load) begin
                cpu_fault <= rsp_fault;
                cpu_pa    <= rsp_fault ? '0 : {rsp_frame, va_q[OFF_W-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_page_xlate.sv
// Scoreboard bench: transactions push expected responses, a negedge monitor pops on cpu_ack.
module tb_page_xlate;
    import page_pkg::*;

    logic        SCLK = 1'b0;
    logic        SRST = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [15:0] cpu_va = '0;
    logic        cpu_ack;
    logic [23:0] cpu_pa;
    logic        cpu_fault;
    logic        busy;
    logic        pt_req;
    logic [7:0]  pt_idx;
    logic        pt_ack = 1'b0;
    logic [15:0] pt_ref = '0;
    logic [1:0]  pt_status = '0;
    logic        PINV = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    page_xlate #(.TLB_N(4)) dut (
        .SCLK(SCLK), .SRST(SRST), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_va(cpu_va),
        .cpu_ack(cpu_ack), .cpu_pa(cpu_pa), .cpu_fault(cpu_fault), .busy(busy),
        .pt_req(pt_req), .pt_idx(pt_idx), .pt_ack(pt_ack), .pt_ref(pt_ref),
        .pt_status(pt_status), .PINV(PINV), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 SCLK = ~SCLK;

    typedef struct packed {
        logic [23:0] pa;
        logic        fault;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge SCLK) begin
        if (mon_en && cpu_ack === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_ack", {31'b0, cpu_ack}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("cpu_pa", {8'b0, cpu_pa}, {8'b0, e.pa});
                chk("cpu_fault", {31'b0, cpu_fault}, {31'b0, e.fault});
            end
        end
    end

    // One CPU request; miss=1 means the directory is expected to be walked.
    task automatic xact(input logic [15:0] va, input logic rw, input logic miss,
                        input logic [15:0] frm, input logic [1:0] st,
                        input logic [23:0] epa, input logic efault,
                        input logic pinv, input logic poke);
        int n;
        q.push_back({epa, efault});
        @(negedge SCLK);
        cpu_req = 1'b1; cpu_rw = rw; cpu_va = va;
        @(negedge SCLK);
        cpu_req = 1'b0;
        chk("busy_lookup", {31'b0, busy}, 32'd1);
        if (!miss) begin
            @(negedge SCLK);
            chk("hit_ack_latency", {31'b0, cpu_ack}, 32'd1);
            chk("hit_no_walk", {31'b0, pt_req}, 32'd0);
        end else begin
            n = 0;
            while (pt_req !== 1'b1 && n < 8) begin
                @(negedge SCLK);
                n++;
            end
            chk("walk_latency", n, 32'd1);
            chk("pt_idx", {24'b0, pt_idx}, {24'b0, va[15:8]});
            if (poke) begin
                cpu_req = 1'b1; cpu_va = 16'hFFFF; cpu_rw = 1'b0;
                @(negedge SCLK);
                cpu_req = 1'b0;
                chk("pt_req_held", {31'b0, pt_req}, 32'd1);
            end
            pt_ack = 1'b1; pt_ref = frm; pt_status = st; PINV = pinv;
            @(negedge SCLK);
            pt_ack = 1'b0; pt_ref = '0; pt_status = '0; PINV = 1'b0;
            chk("pt_req_drop", {31'b0, pt_req}, 32'd0);
            chk("miss_ack_latency", {31'b0, cpu_ack}, 32'd1);
        end
        @(negedge SCLK);
        chk("ack_one_cycle", {31'b0, cpu_ack}, 32'd0);
        chk("idle_after_resp", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge SCLK);
        chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
        chk("rst_pa", {8'b0, cpu_pa}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pt_req", {31'b0, pt_req}, 32'd0);
        chk("rst_pt_idx", {24'b0, pt_idx}, 32'd0);
        chk("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        SRST = 1'b1;
        mon_en = 1'b1;

        xact(16'h0312, 0, 1, 16'hABCD, ST_RW, 24'hABCD12, 0, 0, 0);
        chk("miss_cnt_1", {16'b0, miss_cnt}, 32'd1);
        xact(16'h0344, 0, 0, 16'h0, ST_NP, 24'hABCD44, 0, 0, 0);
        chk("hit_cnt_1", {16'b0, hit_cnt}, 32'd1);

        // Read-only page: write faults on the walk, read hits cleanly.
        xact(16'h0577, 1, 1, 16'h1234, ST_RO, 24'h000000, 1, 0, 0);
        xact(16'h0501, 0, 0, 16'h0, ST_NP, 24'h123401, 0, 0, 0);
        chk("hit_cnt_2", {16'b0, hit_cnt}, 32'd2);

        // Not-present is never cached.
        xact(16'h0710, 0, 1, 16'h5555, ST_NP, 24'h000000, 1, 0, 0);
        xact(16'h0710, 0, 1, 16'h5555, ST_NP, 24'h000000, 1, 0, 0);
        chk("miss_cnt_4", {16'b0, miss_cnt}, 32'd4);

        // Fill the remaining slots, then the 5th vpn evicts entry 0 (vpn 03).
        xact(16'h1001, 0, 1, 16'h1000, ST_RW, 24'h100001, 0, 0, 0);
        xact(16'h1101, 0, 1, 16'h1100, ST_RW, 24'h110001, 0, 0, 0);
        xact(16'h1201, 0, 1, 16'h1200, ST_RW, 24'h120001, 0, 0, 0);
        xact(16'h0399, 0, 1, 16'hABCE, ST_RW, 24'hABCE99, 0, 0, 0);
        chk("miss_cnt_8", {16'b0, miss_cnt}, 32'd8);
        xact(16'h1034, 0, 0, 16'h0, ST_NP, 24'h100034, 0, 0, 0);
        chk("hit_cnt_3", {16'b0, hit_cnt}, 32'd3);

        // Invalidate coincident with pt_ack: response delivered, fill discarded.
        xact(16'h2001, 0, 1, 16'h2020, ST_RW, 24'h202001, 0, 1, 0);
        xact(16'h2002, 0, 1, 16'h2021, ST_RW, 24'h202102, 0, 0, 0);
        xact(16'h1034, 0, 1, 16'h1000, ST_RW, 24'h100034, 0, 0, 0);
        chk("miss_cnt_11", {16'b0, miss_cnt}, 32'd11);
        xact(16'h2003, 1, 0, 16'h0, ST_NP, 24'h202103, 0, 0, 0);

        // Reserved status faults; a cpu_req during the walk is dropped.
        xact(16'h3007, 1, 1, 16'h3333, ST_RSV, 24'h000000, 1, 0, 1);
        chk("miss_cnt_12", {16'b0, miss_cnt}, 32'd12);
        chk("hit_cnt_4", {16'b0, hit_cnt}, 32'd4);
        xact(16'h2004, 0, 0, 16'h0, ST_NP, 24'h202104, 0, 0, 0);
        chk("hit_cnt_5", {16'b0, hit_cnt}, 32'd5);

        // Reset mid-walk, then a stray pt_ack must not produce a response.
        @(negedge SCLK);
        cpu_req = 1'b1; cpu_va = 16'h4000; cpu_rw = 1'b0;
        @(negedge SCLK);
        cpu_req = 1'b0;
        @(negedge SCLK);
        chk("walk_before_rst", {31'b0, pt_req}, 32'd1);
        SRST = 1'b0;
        @(negedge SCLK);
        chk("rst_walk_pt_req", {31'b0, pt_req}, 32'd0);
        chk("rst_walk_busy", {31'b0, busy}, 32'd0);
        chk("rst_walk_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        SRST = 1'b1;
        pt_ack = 1'b1; pt_ref = 16'h4444; pt_status = ST_RW;
        @(negedge SCLK);
        pt_ack = 1'b0; pt_ref = '0; pt_status = '0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_ack", {31'b0, cpu_ack}, 32'd0);
            @(negedge SCLK);
        end
        chk("stray_busy", {31'b0, busy}, 32'd0);

        // TLB was flushed by reset: former hit now misses.
        xact(16'h0312, 0, 1, 16'hABCD, ST_RW, 24'hABCD12, 0, 0, 0);
        chk("miss_cnt_after_rst", {16'b0, miss_cnt}, 32'd1);

        @(negedge SCLK);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
